// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction-memory line responder.
package mem_pkg;

  localparam int unsigned LineSize       = 128;
  localparam int unsigned NrWordsPerLine = 4;
  localparam int unsigned ByteOffsetBits = 4;

  typedef logic [LineSize-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/line_ram.sv
// Line-organised backing store: one synchronous write port, one synchronous read port.
module line_ram
  import mem_pkg::*;
#(
  parameter int unsigned NrLines = 1024
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(NrLines)-1:0] waddr_i,
  input  line_t                      wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(NrLines)-1:0] raddr_i,
  output line_t                      rdata_o
);

  line_t mem_q [NrLines];

  // Both ports update at the same edge, so a same-address read sees the old line.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/imem_line_responder.sv
// Memory-side responder for instruction-cache line refills with fixed latency.
module imem_line_responder
  import mem_pkg::*;
#(
  parameter int unsigned NrLines = 1024,
  parameter int unsigned Latency = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [31:0]                mem_addr_i,
  input  logic                       mem_read_en_i,
  output logic                       mem_read_valid_o,
  output line_t                      mem_read_data_o,
  output logic                       busy_o,
  input  logic                       load_en_i,
  input  logic [$clog2(NrLines)-1:0] load_line_i,
  input  line_t                      load_data_i
);

  localparam int unsigned IdxW = $clog2(NrLines);
  localparam int unsigned CntW = $clog2(Latency + 1);

  resp_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] req_idx;
  logic [IdxW-1:0] rd_idx;
  logic            rd_en;
  line_t           rd_data;
  logic            addr_unused;

  // Upper address bits alias by wrap-around; byte offset within a line is irrelevant.
  assign req_idx     = mem_addr_i[ByteOffsetBits +: IdxW];
  assign addr_unused = ^{mem_addr_i[31:ByteOffsetBits+IdxW], mem_addr_i[ByteOffsetBits-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read_en_i) begin
          idx_d  = req_idx;
          rd_idx = req_idx;
          if (Latency == 1) begin
            state_d = RESP;
            rd_en   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CntW'(Latency - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  line_ram #(
    .NrLines(NrLines)
  ) u_line_ram (
    .clk_i  (clk_i),
    .we_i   (load_en_i),
    .waddr_i(load_line_i),
    .wdata_i(load_data_i),
    .re_i   (rd_en),
    .raddr_i(rd_idx),
    .rdata_o(rd_data)
  );

  // Data is gated by the registered state so reset clears it immediately.
  assign mem_read_valid_o = (state_q == RESP);
  assign mem_read_data_o  = (state_q == RESP) ? rd_data : '0;
  assign busy_o           = (state_q != IDLE);

endmodule
